dmi_auth_ctrl: RTL and testbench
================================

DMI_AUTH_CTRL -- requirements
Module: dmi_auth_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 7, DMI address width.
REQ-002 SHALL have parameter DBITS, default 32, DMI data width.
REQ-003 SHALL have parameter PW_WORDS, default 4 (legal 1..16), password length in DBITS words.
REQ-004 SHALL have parameter MAX_FAILS, default 3 (legal 1..15), failed attempts before lockout.
REQ-005 SHALL have parameter LOCK_CYCLES, default 1024 (legal 2..2^20), lockout duration in clocks.
REQ-006 SHALL have the following ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  single-cycle command strobe (update-DR).
- cmd_op_i  in  2  command: 0 NOP, 1 READ, 2 WRITE, 3 PASSWORD word.
- cmd_addr_i  in  ABITS  command address.
- cmd_data_i  in  DBITS  command write data or password word.
- err_clr_i  in  1  clears sticky error (dmireset).
- we_flag_i  in  1  when 1, READ also requires unlock.
- relock_i  in  1  drops unlock.
- req_valid_o  out  1  DMI request valid.
- req_ready_i  in  1  DMI request accepted.
- req_addr_o  out  ABITS  request address.
- req_data_o  out  DBITS  request data.
- req_op_o  out  2  1 read, 2 write.
- resp_valid_i  in  1  DMI response valid.
- resp_data_i  in  DBITS  response data.
- rd_data_o  out  DBITS  last read data, for capture-DR.
- err_o  out  2  sticky status: 0 ok, 2 denied, 3 busy.
- busy_o  out  1  state is not IDLE.
- hash_start_o  out  1  one-cycle hash start pulse.
- hash_msg_o  out  PW_WORDS*DBITS  collected password; word 0 in the LSBs.
- hash_ready_i  in  1  hash engine idle.
- hash_valid_i  in  1  hash result valid.
- hash_i  in  256  computed hash.
- exp_hash_i  in  256  expected hash.
- unlock_o  out  1  authenticated.
- lockout_o  out  1  lockout active.

Function
REQ-007 SHALL implement states IDLE, REQ, RESP, HSTART, HWAIT and LOCKOUT.
REQ-008 In IDLE with cmd_valid_i and err_o==0: READ permitted when unlock_o or !we_flag_i; WRITE permitted only when unlock_o.
REQ-009 A permitted READ or WRITE SHALL latch addr, data and op, then go to REQ on the next cycle.
REQ-010 A non-permitted READ or WRITE SHALL set err_o=2 and remain in IDLE.
REQ-011 In REQ, req_valid_o=1 and req_addr_o, req_data_o and req_op_o SHALL stay stable until req_ready_i; the cycle after acceptance the state SHALL be RESP.
REQ-012 In RESP, on resp_valid_i: a READ SHALL load rd_data_o from resp_data_i; the state SHALL return to IDLE. Minimum command-to-IDLE latency is 3 cycles.
REQ-013 PASSWORD SHALL store cmd_data_i in word slot pw_idx and increment pw_idx; when pw_idx reaches PW_WORDS it SHALL wrap to 0 and the state SHALL go to HSTART.
REQ-014 In HSTART, when hash_ready_i, SHALL pulse hash_start_o for exactly 1 cycle and enter HWAIT.
REQ-015 In HWAIT, on hash_valid_i:
- match (hash_i==exp_hash_i): set unlock_o, clear fail_cnt, go IDLE.
- mismatch: increment fail_cnt and clear unlock_o.
REQ-016 On the cycle after HWAIT exits, hash_msg_o SHALL be zero; password material SHALL not persist.
REQ-017 cmd_valid_i while busy_o SHALL set err_o=3 and SHALL be otherwise ignored.
REQ-018 While err_o!=0, cmd_valid_i SHALL be ignored.
REQ-019 err_clr_i SHALL clear err_o. If err_clr_i and an error event occur in the same cycle, err_clr_i wins.
REQ-020 relock_i SHALL clear unlock_o and pw_idx in any state; relock_i SHALL win over a simultaneous hash match.
REQ-021 NOP SHALL have no effect.

Reset
REQ-022 rst_i SHALL asynchronously force:
- state IDLE;
- all outputs 0 (req_*, rd_data_o, err_o, busy_o, hash_start_o, hash_msg_o, unlock_o, lockout_o);
- pw_idx=0, fail_cnt=0, lockout counter=0.
REQ-023 Reset asserted mid-transaction or mid-hash SHALL abandon the operation with no further req_valid_o or hash_start_o.

Configuration
REQ-024 With macro DMI_AUTH_LOCKOUT_EN defined, the mismatch that brings fail_cnt to MAX_FAILS SHALL:
- enter LOCKOUT and set lockout_o for exactly LOCK_CYCLES cycles;
- during LOCKOUT, every cmd_valid_i SHALL set err_o=2;
- on exit, clear fail_cnt and return to IDLE.
REQ-025 Without DMI_AUTH_LOCKOUT_EN, a mismatch SHALL return to IDLE, fail_cnt saturates at MAX_FAILS, and lockout_o is tied to 0.

Verification
REQ-026 Reset, then READ addr 0x11 with we_flag_i=0 and resp_data_i=0xDEADBEEF -> req_valid_o asserted with op 1 / addr 0x11, rd_data_o=0xDEADBEEF, err_o=0.
REQ-027 WRITE while locked -> err_o=2, no req_valid_o; then err_clr_i -> err_o=0.
REQ-028 4 PASSWORD words 0x1,0x2,0x3,0x4 with a matching hash -> hash_msg_o=0x4_3_2_1 word-packed, one hash_start_o pulse, unlock_o=1; WRITE 0xCAFE to 0x04 -> accepted.
REQ-029 READ issued, then cmd_valid_i in REQ -> err_o=3; the in-flight READ still completes.
REQ-030 With DMI_AUTH_LOCKOUT_EN and LOCK_CYCLES=8, 3 mismatching passwords -> lockout_o high for exactly 8 cycles, commands during it give err_o=2, then fail_cnt=0.
REQ-031 rst_i asserted in HWAIT -> all outputs 0 the same cycle; a later hash_valid_i is ignored.

Source files
------------

// File: rtl/dmi_auth_ctrl.sv
// ---------------------------------------------------------------------------
// dmi_auth_ctrl
//
// Gatekeeper between a debug-transport command port and the DMI bus.
// READ/WRITE commands are forwarded as a single outstanding DMI request only
// when the unlock state allows it. PASSWORD words are collected into a
// message buffer; a full buffer is handed to an external hash engine and
// the returned digest is compared with the expected hash to grant unlock.
//
// Optional feature macro: DMI_AUTH_LOCKOUT_EN
//   defined   : MAX_FAILS consecutive mismatches enter a LOCKOUT state for
//               LOCK_CYCLES clocks, during which commands are denied.
//   undefined : mismatches simply return to IDLE, fail count saturates,
//               lockout_o is tied low.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   cmd_valid_i/op/addr/data  one-cycle command strobe and payload
//   err_clr_i                 clears the sticky error code
//   we_flag_i                 when set, READs also require unlock
//   relock_i                  drops unlock and restarts password entry
//   req_*                     DMI request (valid/ready handshake)
//   resp_valid_i/resp_data_i  DMI response
//   rd_data_o                 last READ response data
//   err_o                     sticky status: 0 ok, 2 denied, 3 busy
//   busy_o                    controller not in IDLE
//   hash_*                    hash engine handshake and collected message
//   exp_hash_i                expected digest
//   unlock_o, lockout_o       authentication status
// ---------------------------------------------------------------------------
module dmi_auth_ctrl #(
    parameter int ABITS       = 7,
    parameter int DBITS       = 32,
    parameter int PW_WORDS    = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    input  logic [1:0]                cmd_op_i,
    input  logic [ABITS-1:0]          cmd_addr_i,
    input  logic [DBITS-1:0]          cmd_data_i,
    input  logic                      err_clr_i,
    input  logic                      we_flag_i,
    input  logic                      relock_i,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output logic [ABITS-1:0]          req_addr_o,
    output logic [DBITS-1:0]          req_data_o,
    output logic [1:0]                req_op_o,
    input  logic                      resp_valid_i,
    input  logic [DBITS-1:0]          resp_data_i,
    output logic [DBITS-1:0]          rd_data_o,
    output logic [1:0]                err_o,
    output logic                      busy_o,
    output logic                      hash_start_o,
    output logic [PW_WORDS*DBITS-1:0] hash_msg_o,
    input  logic                      hash_ready_i,
    input  logic                      hash_valid_i,
    input  logic [255:0]              hash_i,
    input  logic [255:0]              exp_hash_i,
    output logic                      unlock_o,
    output logic                      lockout_o
);

    localparam int IW = (PW_WORDS > 1) ? $clog2(PW_WORDS) : 1;

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_PW    = 2'd3;

    localparam logic [1:0] ERR_DENIED = 2'd2;
    localparam logic [1:0] ERR_BUSY   = 2'd3;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] RESP    = 3'd2;
    localparam logic [2:0] HSTART  = 3'd3;
    localparam logic [2:0] HWAIT   = 3'd4;
    localparam logic [2:0] LOCKOUT = 3'd5;

    logic [2:0]       state_reg;
    logic [ABITS-1:0] req_addr_reg;
    logic [DBITS-1:0] req_data_reg;
    logic [1:0]       req_op_reg;
    logic [DBITS-1:0] rd_data_reg;
    logic [1:0]       err_reg;
    logic             unlock_reg;
    logic [IW-1:0]    pw_idx_reg;
    logic [3:0]       fail_cnt_reg;
    logic [DBITS-1:0] pw_reg [PW_WORDS];

    logic in_idle;
    logic accept;
    logic rd_ok;
    logic go_req;
    logic deny;
    logic pw_wr;
    logic pw_last;
    logic hash_done;
    logic hash_match;
    logic busy_err;
    logic lock_err;
    logic lock_trip;
    logic lock_done;

    // Commands are only acted upon from IDLE with a clean error status.
    assign in_idle    = (state_reg == IDLE);
    assign accept     = in_idle && cmd_valid_i && (err_reg == 2'd0);
    assign rd_ok      = unlock_reg || !we_flag_i;
    assign go_req     = accept && (((cmd_op_i == OP_READ) && rd_ok) ||
                                   ((cmd_op_i == OP_WRITE) && unlock_reg));
    assign deny       = accept && (((cmd_op_i == OP_READ) && !rd_ok) ||
                                   ((cmd_op_i == OP_WRITE) && !unlock_reg));
    assign pw_wr      = accept && (cmd_op_i == OP_PW);
    assign pw_last    = (pw_idx_reg == IW'(PW_WORDS - 1));
    assign hash_done  = (state_reg == HWAIT) && hash_valid_i;
    assign hash_match = (hash_i == exp_hash_i);

    // A busy strobe only flags an error if none is pending; LOCKOUT has its
    // own (denied) error code that always overrides.
    assign busy_err = cmd_valid_i && !in_idle && (state_reg != LOCKOUT) && (err_reg == 2'd0);
    assign lock_err = cmd_valid_i && (state_reg == LOCKOUT);

`ifdef DMI_AUTH_LOCKOUT_EN
    localparam int LCW = $clog2(LOCK_CYCLES);

    logic [LCW-1:0] lock_cnt_reg;

    assign lock_trip = hash_done && !hash_match && (fail_cnt_reg == 4'(MAX_FAILS - 1));
    assign lock_done = (lock_cnt_reg == '0);
    assign lockout_o = (state_reg == LOCKOUT);

    // Loaded with LOCK_CYCLES-1 on entry so LOCKOUT lasts exactly LOCK_CYCLES.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_cnt_reg <= '0;
        end else if (lock_trip) begin
            lock_cnt_reg <= LCW'(LOCK_CYCLES - 1);
        end else if ((state_reg == LOCKOUT) && !lock_done) begin
            lock_cnt_reg <= lock_cnt_reg - 1'b1;
        end
    end
`else
    assign lock_trip = 1'b0;
    assign lock_done = 1'b1;
    assign lockout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (go_req) begin
                        state_reg <= REQ;
                    end else if (pw_wr && pw_last) begin
                        state_reg <= HSTART;
                    end
                end
                REQ:     if (req_ready_i)  state_reg <= RESP;
                RESP:    if (resp_valid_i) state_reg <= IDLE;
                HSTART:  if (hash_ready_i) state_reg <= HWAIT;
                HWAIT:   if (hash_valid_i) state_reg <= lock_trip ? LOCKOUT : IDLE;
                LOCKOUT: if (lock_done)    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr_reg <= '0;
            req_data_reg <= '0;
            req_op_reg   <= '0;
        end else if (go_req) begin
            req_addr_reg <= cmd_addr_i;
            req_data_reg <= cmd_data_i;
            req_op_reg   <= cmd_op_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_reg <= '0;
        end else if ((state_reg == RESP) && resp_valid_i && (req_op_reg == OP_READ)) begin
            rd_data_reg <= resp_data_i;
        end
    end

    // err_clr_i has priority over any error raised in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg <= 2'd0;
        end else if (err_clr_i) begin
            err_reg <= 2'd0;
        end else if (deny || lock_err) begin
            err_reg <= ERR_DENIED;
        end else if (busy_err) begin
            err_reg <= ERR_BUSY;
        end
    end

    // relock_i beats a simultaneous hash match.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            unlock_reg <= 1'b0;
        end else if (relock_i) begin
            unlock_reg <= 1'b0;
        end else if (hash_done) begin
            unlock_reg <= hash_match;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pw_idx_reg <= '0;
        end else if (relock_i) begin
            pw_idx_reg <= '0;
        end else if (pw_wr) begin
            pw_idx_reg <= pw_last ? '0 : pw_idx_reg + 1'b1;
        end
    end

    // Mismatches count up and saturate at MAX_FAILS; with lockout enabled
    // the count reaches MAX_FAILS only on the tripping mismatch and is
    // cleared again when LOCKOUT ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_cnt_reg <= '0;
        end else if (hash_done) begin
            if (hash_match) begin
                fail_cnt_reg <= '0;
            end else if (fail_cnt_reg < 4'(MAX_FAILS)) begin
                fail_cnt_reg <= fail_cnt_reg + 1'b1;
            end
        end else if ((state_reg == LOCKOUT) && lock_done) begin
            fail_cnt_reg <= '0;
        end
    end

    // Password buffer: wiped as soon as the hash result arrives so no
    // password material outlives the comparison.
    generate
        for (genvar gi = 0; gi < PW_WORDS; gi++) begin : g_pw
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pw_reg[gi] <= '0;
                end else if (hash_done) begin
                    pw_reg[gi] <= '0;
                end else if (pw_wr && (pw_idx_reg == IW'(gi))) begin
                    pw_reg[gi] <= cmd_data_i;
                end
            end
            assign hash_msg_o[gi*DBITS +: DBITS] = pw_reg[gi];
        end
    endgenerate

    assign req_valid_o  = (state_reg == REQ);
    assign req_addr_o   = req_addr_reg;
    assign req_data_o   = req_data_reg;
    assign req_op_o     = req_op_reg;
    assign rd_data_o    = rd_data_reg;
    assign err_o        = err_reg;
    assign busy_o       = !in_idle;
    assign hash_start_o = (state_reg == HSTART) && hash_ready_i;
    assign unlock_o     = unlock_reg;

endmodule

// File: tb/tb_dmi_auth_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmi_auth_ctrl
//
// Self-checking bench for dmi_auth_ctrl. A transaction-level model keeps the
// unlock flag, sticky error, last read data, queued password words and the
// mismatch count; each transaction task drives the DUT cycle by cycle and
// compares the observable outputs with the model. A short vector table
// covers the permission matrix, hand sequences cover reset, lockout and
// priority corners, and a randomized loop mixes everything.
// ---------------------------------------------------------------------------
module tb_dmi_auth_ctrl;

    localparam int AB  = 7;
    localparam int DB  = 32;
    localparam int PWN = 4;
    localparam int MF  = 3;
    localparam int LC  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [1:0]        cmd_op;
    logic [AB-1:0]     cmd_addr;
    logic [DB-1:0]     cmd_data;
    logic              err_clr;
    logic              we_flag;
    logic              relock;
    logic              req_valid_o;
    logic              req_ready;
    logic [AB-1:0]     req_addr_o;
    logic [DB-1:0]     req_data_o;
    logic [1:0]        req_op_o;
    logic              resp_valid;
    logic [DB-1:0]     resp_data;
    logic [DB-1:0]     rd_data_o;
    logic [1:0]        err_o;
    logic              busy_o;
    logic              hash_start_o;
    logic [PWN*DB-1:0] hash_msg_o;
    logic              hash_ready;
    logic              hash_valid;
    logic [255:0]      hash_in;
    logic [255:0]      exp_hash;
    logic              unlock_o;
    logic              lockout_o;

    always #5 clk = ~clk;

    dmi_auth_ctrl #(
        .ABITS(AB), .DBITS(DB), .PW_WORDS(PWN), .MAX_FAILS(MF), .LOCK_CYCLES(LC)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .err_clr_i(err_clr), .we_flag_i(we_flag), .relock_i(relock),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready), .req_addr_o(req_addr_o),
        .req_data_o(req_data_o), .req_op_o(req_op_o),
        .resp_valid_i(resp_valid), .resp_data_i(resp_data), .rd_data_o(rd_data_o),
        .err_o(err_o), .busy_o(busy_o),
        .hash_start_o(hash_start_o), .hash_msg_o(hash_msg_o), .hash_ready_i(hash_ready),
        .hash_valid_i(hash_valid), .hash_i(hash_in), .exp_hash_i(exp_hash),
        .unlock_o(unlock_o), .lockout_o(lockout_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    int hs_cnt   = 0;
    bit poke_en  = 1'b0;

    // Reference model state
    bit          m_unlock;
    logic [1:0]  m_err;
    logic [31:0] m_rd;
    logic [31:0] m_pw[$];
    int          m_fail;

    always @(negedge clk) begin
        if (req_valid_o && req_ready) acc_cnt++;
        if (hash_start_o) hs_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_unlock = 1'b0;
        m_err    = 2'd0;
        m_rd     = '0;
        m_fail   = 0;
        m_pw.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_out"}, {req_valid_o, req_addr_o, req_data_o, req_op_o, rd_data_o,
                             err_o, busy_o, hash_start_o, unlock_o, lockout_o}, '0);
        chk({name, "_msg"}, hash_msg_o, '0);
    endtask

    task automatic err_clear();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        m_err = 2'd0;
        chk("err_clr", err_o, 2'd0);
    endtask

    task automatic relock_t();
        relock = 1'b1;
        step();
        relock = 1'b0;
        m_unlock = 1'b0;
        m_pw.delete();
        chk("relock", unlock_o, 1'b0);
    endtask

    // Optional command while the controller is busy.
    task automatic busy_poke();
        if (poke_en && ($urandom_range(0, 3) == 0)) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(1, 3));
            if (m_err == 2'd0) m_err = 2'd3;
        end
    endtask

    task automatic txn_rw(input logic [1:0] op, input logic [AB-1:0] addr, input logic [DB-1:0] data,
                          input bit we, input logic [DB-1:0] rdat);
        bit permit;
        int a0;
        int stall;
        a0 = acc_cnt;
        permit = (m_err == 2'd0) && (((op == 2'd1) && (m_unlock || !we)) || ((op == 2'd2) && m_unlock));
        if ((m_err == 2'd0) && !permit && ((op == 2'd1) || (op == 2'd2))) m_err = 2'd2;
        we_flag = we; cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        step();
        cmd_valid = 1'b0; cmd_addr = AB'($urandom); cmd_data = $urandom;
        if (permit) begin
            chk("req_issue", {req_valid_o, req_op_o, req_addr_o, req_data_o}, {1'b1, op, addr, data});
            stall = $urandom_range(0, 3);
            for (int i = 0; i < stall; i++) begin
                busy_poke();
                step();
                cmd_valid = 1'b0;
                chk("req_hold", {req_valid_o, req_op_o, req_addr_o, req_data_o}, {1'b1, op, addr, data});
            end
            req_ready = 1'b1;
            step();
            req_ready = 1'b0;
            chk("req_drop", req_valid_o, 1'b0);
            stall = $urandom_range(0, 2);
            for (int i = 0; i < stall; i++) begin
                busy_poke();
                step();
                cmd_valid = 1'b0;
            end
            resp_valid = 1'b1; resp_data = rdat;
            step();
            resp_valid = 1'b0; resp_data = $urandom;
            if (op == 2'd1) m_rd = rdat;
        end else begin
            step();
            step();
        end
        chk("busy_idle", busy_o, 1'b0);
        chk("err", err_o, m_err);
        chk("rd_data", rd_data_o, m_rd);
        chk("unlock_keep", unlock_o, m_unlock);
        chk("issue_cnt", acc_cnt - a0, permit);
    endtask

    task automatic pw_word(input logic [DB-1:0] w, output bit full);
        full = 1'b0;
        if (m_err == 2'd0) begin
            m_pw.push_back(w);
            full = (m_pw.size() == PWN);
        end
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_data = w;
        step();
        cmd_valid = 1'b0;
        chk("pw_busy", busy_o, full);
    endtask

`ifdef DMI_AUTH_LOCKOUT_EN
    task automatic lockout_run();
        int n = 0;
        while ((lockout_o === 1'b1) && (n < 100)) begin
            n++;
            if ($urandom_range(0, 1) == 1) begin
                cmd_valid = 1'b1;
                cmd_op    = 2'($urandom_range(1, 3));
                m_err     = 2'd2;
            end
            step();
            cmd_valid = 1'b0;
        end
        chk("lockout_len", n, LC);
        chk("lockout_err", err_o, m_err);
        chk("lockout_exit", busy_o, 1'b0);
    endtask
`endif

    // Drives the hash engine side once the buffer is full (state HSTART).
    task automatic hash_phase(input bit match, input bit rl);
        logic [255:0] msg;
        int h0;
        int dly;
        bit tripped;
        msg = '0;
        h0 = hs_cnt;
        tripped = 1'b0;
        for (int i = 0; i < PWN; i++) msg |= 256'(m_pw[i]) << (32 * i);
        hash_ready = 1'b0;
        dly = $urandom_range(0, 2);
        for (int i = 0; i < dly; i++) begin
            busy_poke();
            chk("hstart_wait", hash_start_o, 1'b0);
            step();
            cmd_valid = 1'b0;
        end
        hash_ready = 1'b1;
        #1;
        chk("hash_start", hash_start_o, 1'b1);
        chk("hash_msg", hash_msg_o, msg);
        step();
        hash_ready = 1'($urandom_range(0, 1));
        chk("hstart_once", hash_start_o, 1'b0);
        dly = $urandom_range(0, 2);
        for (int i = 0; i < dly; i++) begin
            busy_poke();
            step();
            cmd_valid = 1'b0;
        end
        hash_valid = 1'b1;
        hash_in = match ? exp_hash : (exp_hash ^ (256'(1) << $urandom_range(0, 255)));
        relock = rl;
        step();
        hash_valid = 1'b0; relock = 1'b0; hash_ready = 1'b0;
        m_pw.delete();
        chk("msg_clear", hash_msg_o, '0);
        chk("hs_pulses", hs_cnt - h0, 1);
        if (match) begin
            m_unlock = !rl;
            m_fail   = 0;
        end else begin
            m_unlock = 1'b0;
`ifdef DMI_AUTH_LOCKOUT_EN
            tripped = (m_fail + 1 == MF);
            if (tripped) begin
                lockout_run();
                m_fail = 0;
            end else begin
                m_fail++;
            end
`else
            if (m_fail < MF) m_fail++;
`endif
        end
        if (!tripped) begin
            chk("no_lockout", lockout_o, 1'b0);
            chk("hash_idle", busy_o, 1'b0);
        end
        chk("hash_unlock", unlock_o, m_unlock);
        chk("hash_err", err_o, m_err);
    endtask

    task automatic pw_round(input bit match);
        bit full;
        bit blocked;
        for (int k = 0; k < PWN; k++) begin
            blocked = (m_err != 2'd0);
            pw_word($urandom, full);
            if (full) begin
                hash_phase(match, 1'b0);
                break;
            end
            if (blocked) break;
        end
    endtask

    task automatic unlock_seq();
        bit full;
        relock_t();
        for (int i = 1; i <= PWN; i++) pw_word(32'(i), full);
        hash_phase(1'b1, 1'b0);
    endtask

    typedef struct {
        logic [1:0]    op;
        bit            we;
        bit            unl;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
        logic [DB-1:0] rdat;
        logic [1:0]    exp_err;
        int            exp_issue;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit full;
        int a0;
        int h0;

        tbl[0] = '{2'd1, 1'b0, 1'b0, 7'h11, 32'h0,      32'hDEADBEEF, 2'd0, 1};
        tbl[1] = '{2'd2, 1'b0, 1'b0, 7'h04, 32'h1234,   32'h0,        2'd2, 0};
        tbl[2] = '{2'd1, 1'b1, 1'b0, 7'h20, 32'h0,      32'h55AA55AA, 2'd2, 0};
        tbl[3] = '{2'd1, 1'b1, 1'b1, 7'h21, 32'h0,      32'h0BADF00D, 2'd0, 1};
        tbl[4] = '{2'd2, 1'b0, 1'b1, 7'h04, 32'hCAFE,   32'h0,        2'd0, 1};
        tbl[5] = '{2'd0, 1'b0, 1'b0, 7'h33, 32'hFFFF,   32'h0,        2'd0, 0};
        tbl[6] = '{2'd1, 1'b0, 1'b1, 7'h7F, 32'h0,      32'h13579BDF, 2'd0, 1};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        err_clr = 1'b0; we_flag = 1'b0; relock = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        hash_ready = 1'b0; hash_valid = 1'b0; hash_in = '0;
        exp_hash = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        step();
        model_reset();

        // Four password words 1..4, matching hash.
        relock_t();
        for (int i = 1; i <= PWN; i++) pw_word(32'(i), full);
        chk("hstart_state", busy_o, 1'b1);
        chk("msg_4321", hash_msg_o, 128'h00000004_00000003_00000002_00000001);
        hash_phase(1'b1, 1'b0);
        chk("unlocked", unlock_o, 1'b1);

        // Permission matrix.
        for (int r = 0; r < 7; r++) begin
            err_clear();
            if (tbl[r].unl) unlock_seq();
            else relock_t();
            a0 = acc_cnt;
            txn_rw(tbl[r].op, tbl[r].addr, tbl[r].data, tbl[r].we, tbl[r].rdat);
            chk($sformatf("tbl%0d_err", r), err_o, tbl[r].exp_err);
            chk($sformatf("tbl%0d_issue", r), acc_cnt - a0, tbl[r].exp_issue);
            if ((tbl[r].op == 2'd1) && (tbl[r].exp_issue == 1))
                chk($sformatf("tbl%0d_rd", r), rd_data_o, tbl[r].rdat);
        end

        // err_clr wins over a denial in the same cycle.
        err_clear();
        relock_t();
        a0 = acc_cnt;
        err_clr = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd2;
        step();
        err_clr = 1'b0; cmd_valid = 1'b0;
        step();
        chk("clr_wins_err", err_o, 2'd0);
        chk("clr_wins_issue", acc_cnt - a0, 0);

        // Command during REQ flags busy; the READ still completes.
        we_flag = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 7'h22;
        step();
        cmd_op = 2'd2;
        step();
        cmd_valid = 1'b0;
        chk("busy_err3", err_o, 2'd3);
        chk("busy_req_on", req_valid_o, 1'b1);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'hA5A5_0022;
        step();
        resp_valid = 1'b0;
        m_err = 2'd3; m_rd = 32'hA5A5_0022;
        chk("busy_rd_done", rd_data_o, 32'hA5A5_0022);
        chk("busy_idle_after", busy_o, 1'b0);
        err_clear();

        // relock beats a simultaneous match.
        relock_t();
        for (int i = 0; i < PWN; i++) pw_word($urandom, full);
        hash_phase(1'b1, 1'b1);

        // Mismatch run: lockout (if built in) then proof that the count restarted.
        err_clear();
        unlock_seq();
        for (int k = 0; k < MF + 2; k++) begin
            err_clear();
            pw_round(1'b0);
        end
        err_clear();

        // Reset during HWAIT.
        unlock_seq();
        for (int i = 0; i < PWN; i++) pw_word($urandom, full);
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("rst_hwait");
        step();
        rst = 1'b0;
        model_reset();
        h0 = hs_cnt;
        hash_valid = 1'b1; hash_in = exp_hash; hash_ready = 1'b1;
        step();
        hash_valid = 1'b0; hash_ready = 1'b0;
        step();
        chk("rst_hwait_unlock", unlock_o, 1'b0);
        chk("rst_hwait_busy", busy_o, 1'b0);
        chk("rst_hwait_hs", hs_cnt - h0, 0);

        // Reset during REQ.
        we_flag = 1'b0; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 7'h05;
        step();
        cmd_valid = 1'b0;
        chk("rst_req_pre", req_valid_o, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero("rst_req");
        step();
        rst = 1'b0;
        model_reset();
        a0 = acc_cnt;
        req_ready = 1'b1; resp_valid = 1'b1; resp_data = 32'hFFFF_FFFF;
        repeat (3) step();
        req_ready = 1'b0; resp_valid = 1'b0;
        chk("rst_req_issue", acc_cnt - a0, 0);
        chk("rst_req_rd", rd_data_o, m_rd);

        // Randomized mix.
        poke_en = 1'b1;
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: txn_rw(2'd1, AB'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom);
                3, 4:    txn_rw(2'd2, AB'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom);
                5: begin
                    pw_word($urandom, full);
                    if (full) hash_phase(1'($urandom_range(0, 1)), 1'b0);
                end
                6:       pw_round(1'($urandom_range(0, 1)));
                7:       err_clear();
                8:       relock_t();
                default: txn_rw(2'd0, AB'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
